// File: rtl/letc_core_pkg.sv
// Shared types for the core trace checker: expected-trace entry layout and checker FSM states.
package letc_core_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rd_val;
    logic [4:0]  rd_idx;
    logic        rd_we;
  } trace_entry_t;

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_DONE} chk_state_e;

endpackage

// File: rtl/letc_core_trace_cmp.sv
// Combinational compare of one retired instruction against one expected-trace entry.
module letc_core_trace_cmp
  import letc_core_pkg::*;
(
  input  trace_entry_t entry,
  input  logic [31:0]  pc,
  input  logic         rd_we,
  input  logic [4:0]   rd_idx,
  input  logic [31:0]  rd_val,
  output logic         match
);
  logic exp_we, act_we;

  always_comb begin
    // Writes to x0 are architecturally invisible, so both sides drop them.
    exp_we = entry.rd_we && (entry.rd_idx != 5'd0);
    act_we = rd_we && (rd_idx != 5'd0);
    match  = (entry.pc == pc) && (exp_we == act_we) &&
             (!exp_we || ((entry.rd_idx == rd_idx) && (entry.rd_val == rd_val)));
  end

endmodule

// File: rtl/letc_core_trace_checker.sv
// Compares the retired-instruction stream against a preloaded expected trace.
// Optional LETC_TRACE_CHECKER_FIRST_FAIL_CAPTURE_EN adds first-mismatch capture outputs.
module letc_core_trace_checker
  import letc_core_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load_we,
  input  logic [AW-1:0] i_load_addr,
  input  trace_entry_t  i_load_entry,
  input  logic [AW:0]   i_exp_count,
  input  logic          i_start,
  input  logic          i_commit_valid,
  input  logic [31:0]   i_commit_pc,
  input  logic          i_commit_rd_we,
  input  logic [4:0]    i_commit_rd_idx,
  input  logic [31:0]   i_commit_rd_val,
  input  logic          i_exit,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_pass,
  output logic          o_fail,
  output logic [AW:0]   o_checked_count,
`ifdef LETC_TRACE_CHECKER_FIRST_FAIL_CAPTURE_EN
  output logic [AW:0]   o_fail_idx,
  output logic [31:0]   o_fail_pc,
  output logic [31:0]   o_fail_val,
`endif
  output logic [15:0]   o_mismatch_count
);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  chk_state_e   state, state_nxt;
  trace_entry_t mem [DEPTH];
  trace_entry_t rd_entry;
  logic [AW:0]  ptr, cnt, checked, ptr_post, cnt_clamped;
  logic [15:0]  mism, mism_nxt;
  logic [16:0]  mism_sum;
  logic         match, in_check, start_ok, do_commit, do_exit;
  logic         overrun, cmp_fail, underrun;

  assign rd_entry = mem[ptr[AW-1:0]];

  letc_core_trace_cmp u_cmp (
    .entry  (rd_entry),
    .pc     (i_commit_pc),
    .rd_we  (i_commit_rd_we),
    .rd_idx (i_commit_rd_idx),
    .rd_val (i_commit_rd_val),
    .match  (match)
  );

  always_comb begin
    in_check    = (state == ST_CHECK);
    start_ok    = i_start && !in_check;
    do_commit   = in_check && i_commit_valid;
    do_exit     = in_check && i_exit;
    cnt_clamped = (i_exp_count > DEPTH_W) ? DEPTH_W : i_exp_count;
    overrun     = (ptr >= cnt);
    cmp_fail    = do_commit && (overrun || !match);
    // A commit in the exit cycle is consumed before the underrun test.
    ptr_post    = (do_commit && !overrun) ? ptr + 1'b1 : ptr;
    underrun    = do_exit && (ptr_post != cnt);
    mism_sum    = {1'b0, mism} + 17'(cmp_fail) + 17'(underrun);
    mism_nxt    = mism_sum[16] ? 16'hFFFF : mism_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (i_start) state_nxt = ST_CHECK;
      ST_CHECK:         if (i_exit)  state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state == ST_CHECK);
    o_done = (state == ST_DONE);
    o_pass = (state == ST_DONE) && (mism == 16'd0);
    o_fail = (mism != 16'd0);
  end

  // Trace storage is deliberately left out of reset so a preload survives it.
  always_ff @(posedge clk) begin
    if (i_load_we && !in_check) mem[i_load_addr] <= i_load_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      cnt     <= '0;
      checked <= '0;
      mism    <= '0;
    end else if (start_ok) begin
      ptr     <= '0;
      cnt     <= cnt_clamped;
      checked <= '0;
      mism    <= '0;
    end else if (in_check) begin
      ptr  <= ptr_post;
      mism <= mism_nxt;
      if (do_commit && (checked != '1)) checked <= checked + 1'b1;
    end
  end

  assign o_checked_count  = checked;
  assign o_mismatch_count = mism;

`ifdef LETC_TRACE_CHECKER_FIRST_FAIL_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      o_fail_idx <= '0;
      o_fail_pc  <= '0;
      o_fail_val <= '0;
    end else if (mism == 16'd0) begin
      if (cmp_fail) begin
        o_fail_idx <= ptr;
        o_fail_pc  <= i_commit_pc;
        o_fail_val <= i_commit_rd_val;
      end else if (underrun) begin
        o_fail_idx <= cnt;
        o_fail_pc  <= '0;
        o_fail_val <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_letc_core_trace_checker.sv
// Self-checking bench: compare-rule table, directed multi-cycle sequences, randomized runs vs a reference model.
module tb_letc_core_trace_checker;
  import letc_core_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst;
  logic i_load_we;
  logic [AW-1:0] i_load_addr;
  trace_entry_t i_load_entry;
  logic [AW:0] i_exp_count;
  logic i_start, i_commit_valid, i_commit_rd_we, i_exit;
  logic [31:0] i_commit_pc, i_commit_rd_val;
  logic [4:0] i_commit_rd_idx;
  logic o_busy, o_done, o_pass, o_fail;
  logic [AW:0] o_checked_count;
  logic [15:0] o_mismatch_count;
`ifdef LETC_TRACE_CHECKER_FIRST_FAIL_CAPTURE_EN
  logic [AW:0] o_fail_idx;
  logic [31:0] o_fail_pc, o_fail_val;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  letc_core_trace_checker #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .i_load_we(i_load_we), .i_load_addr(i_load_addr), .i_load_entry(i_load_entry),
    .i_exp_count(i_exp_count), .i_start(i_start),
    .i_commit_valid(i_commit_valid), .i_commit_pc(i_commit_pc),
    .i_commit_rd_we(i_commit_rd_we), .i_commit_rd_idx(i_commit_rd_idx),
    .i_commit_rd_val(i_commit_rd_val), .i_exit(i_exit),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_fail(o_fail),
    .o_checked_count(o_checked_count),
`ifdef LETC_TRACE_CHECKER_FIRST_FAIL_CAPTURE_EN
    .o_fail_idx(o_fail_idx), .o_fail_pc(o_fail_pc), .o_fail_val(o_fail_val),
`endif
    .o_mismatch_count(o_mismatch_count)
  );

  typedef struct {
    trace_entry_t e;
    trace_entry_t c;
    logic         exp_match;
  } cmp_vec_t;

  trace_entry_t mdl [DEPTH];

  function automatic trace_entry_t mk(input logic [31:0] pc, input logic we,
                                      input logic [4:0] idx, input logic [31:0] val);
    trace_entry_t t;
    t.pc = pc; t.rd_we = we; t.rd_idx = idx; t.rd_val = val;
    return t;
  endfunction

  // Reference rule: a write to x0 is no write at all.
  function automatic bit model_match(input trace_entry_t e, input trace_entry_t c);
    bit ew, cw;
    ew = e.rd_we && (e.rd_idx != 0);
    cw = c.rd_we && (c.rd_idx != 0);
    if (e.pc != c.pc) return 0;
    if (ew != cw) return 0;
    if (ew && (e.rd_idx != c.rd_idx || e.rd_val != c.rd_val)) return 0;
    return 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input trace_entry_t e);
    i_load_we = 1'b1; i_load_addr = a[AW-1:0]; i_load_entry = e;
    tick();
    i_load_we = 1'b0;
    if (!o_busy) mdl[a] = e;
  endtask

  task automatic start(input int n);
    i_exp_count = n[AW:0]; i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic commit(input trace_entry_t c, input logic ex);
    i_commit_valid = 1'b1; i_commit_pc = c.pc; i_commit_rd_we = c.rd_we;
    i_commit_rd_idx = c.rd_idx; i_commit_rd_val = c.rd_val; i_exit = ex;
    tick();
    i_commit_valid = 1'b0; i_exit = 1'b0;
  endtask

  task automatic do_exit();
    i_exit = 1'b1;
    tick();
    i_exit = 1'b0;
  endtask

  task automatic load_base();
    load(0, mk(32'h0, 1'b1, 5'd1, 32'h5));
    load(1, mk(32'h4, 1'b0, 5'd0, 32'h0));
    load(2, mk(32'h8, 1'b1, 5'd2, 32'hA));
  endtask

  cmp_vec_t vt [10];

  initial begin
    rst = 1'b1; i_load_we = 0; i_load_addr = 0; i_load_entry = '0; i_exp_count = 0;
    i_start = 0; i_commit_valid = 0; i_commit_pc = 0; i_commit_rd_we = 0;
    i_commit_rd_idx = 0; i_commit_rd_val = 0; i_exit = 0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_flags", {o_busy, o_done, o_pass, o_fail}, 4'b0);
    chk("reset_counts", {o_checked_count, o_mismatch_count}, 0);

    // Compare-rule table: {expected entry, commit, match?}
    vt[0] = '{mk(32'h100, 1, 5'd1, 32'h5),  mk(32'h100, 1, 5'd1, 32'h5),  1'b1};
    vt[1] = '{mk(32'h100, 1, 5'd1, 32'h5),  mk(32'h104, 1, 5'd1, 32'h5),  1'b0};
    vt[2] = '{mk(32'h100, 1, 5'd1, 32'h5),  mk(32'h100, 1, 5'd1, 32'h6),  1'b0};
    vt[3] = '{mk(32'h100, 1, 5'd1, 32'h5),  mk(32'h100, 1, 5'd9, 32'h5),  1'b0};
    vt[4] = '{mk(32'h100, 1, 5'd1, 32'h5),  mk(32'h100, 0, 5'd1, 32'h5),  1'b0};
    vt[5] = '{mk(32'h4, 0, 5'd0, 32'h0),    mk(32'h4, 1, 5'd3, 32'h0),    1'b0};
    vt[6] = '{mk(32'h4, 0, 5'd0, 32'h0),    mk(32'h4, 1, 5'd0, 32'h1234), 1'b1};
    vt[7] = '{mk(32'h20, 1, 5'd0, 32'h7),   mk(32'h20, 0, 5'd4, 32'h99),  1'b1};
    vt[8] = '{mk(32'h24, 0, 5'd6, 32'h1),   mk(32'h24, 0, 5'd7, 32'h2),   1'b1};
    vt[9] = '{mk(32'hFFFFFFFC, 1, 5'd31, 32'hFFFFFFFF),
              mk(32'hFFFFFFFC, 1, 5'd31, 32'hFFFFFFFF), 1'b1};
    for (int i = 0; i < 10; i++) begin
      load(0, vt[i].e);
      start(1);
      commit(vt[i].c, 1'b0);
      chk($sformatf("tbl%0d_mism", i), o_mismatch_count, {15'd0, !vt[i].exp_match});
      do_exit();
      chk($sformatf("tbl%0d_pass", i), o_pass, vt[i].exp_match);
    end

    // Clean three-entry run.
    load_base();
    start(3);
    chk("clean_busy", o_busy, 1'b1);
    for (int i = 0; i < 3; i++) commit(mdl[i], 1'b0);
    do_exit();
    chk("clean_flags", {o_busy, o_done, o_pass, o_fail}, 4'b0110);
    chk("clean_counts", {o_checked_count, o_mismatch_count}, {4'd3, 16'd0});
    commit(mdl[0], 1'b0);
    chk("commit_outside_check", o_checked_count, 4'd3);

    // Bad rd_val on the third commit.
    start(3);
    commit(mdl[0], 1'b0); commit(mdl[1], 1'b0);
    commit(mk(32'h8, 1, 5'd2, 32'hB), 1'b0);
    chk("badval_mism", o_mismatch_count, 16'd1);
    do_exit();
    chk("badval_flags", {o_pass, o_fail}, 2'b01);
`ifdef LETC_TRACE_CHECKER_FIRST_FAIL_CAPTURE_EN
    chk("badval_cap", {o_fail_idx, o_fail_pc, o_fail_val}, {4'd2, 32'h8, 32'hB});
`endif

    // Overrun.
    start(2);
    for (int i = 0; i < 3; i++) commit(mdl[i], 1'b0);
    do_exit();
    chk("overrun_counts", {o_checked_count, o_mismatch_count}, {4'd3, 16'd1});

    // Underrun.
    start(3);
    commit(mdl[0], 1'b0); commit(mdl[1], 1'b0);
    do_exit();
    chk("underrun_mism", o_mismatch_count, 16'd1);
`ifdef LETC_TRACE_CHECKER_FIRST_FAIL_CAPTURE_EN
    chk("underrun_cap", {o_fail_idx, o_fail_pc, o_fail_val}, {4'd3, 32'h0, 32'h0});
`endif

    // Last commit coincides with exit.
    start(3);
    commit(mdl[0], 1'b0); commit(mdl[1], 1'b0); commit(mdl[2], 1'b1);
    chk("same_cycle_exit", {o_done, o_pass, o_mismatch_count}, {2'b11, 16'd0});

    // Reset mid-run.
    start(3);
    commit(mk(32'h44, 0, 5'd0, 32'h0), 1'b0);
    chk("pre_rst_fail", o_fail, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrun_rst", {o_busy, o_done, o_pass, o_fail, o_checked_count, o_mismatch_count}, 0);

    // Load attempt while checking must be dropped.
    start(3);
    load(0, mk(32'hDEAD, 1, 5'd5, 32'h55));
    for (int i = 0; i < 3; i++) commit(mdl[i], 1'b0);
    do_exit();
    start(1);
    commit(mk(32'h0, 1, 5'd1, 32'h5), 1'b1);
    chk("load_in_check_dropped", {o_pass, o_mismatch_count}, {1'b1, 16'd0});

    // Count above DEPTH clamps.
    for (int i = 0; i < DEPTH; i++) load(i, mk(32'h1000 + i*4, 1, 5'(i+1), $urandom));
    start(DEPTH + 5);
    for (int i = 0; i < DEPTH; i++) commit(mdl[i], 1'b0);
    do_exit();
    chk("clamp_pass", {o_pass, o_checked_count}, {1'b1, 4'(DEPTH)});

    // Randomized runs against the reference model.
    for (int r = 0; r < 40; r++) begin
      int cnt, k, m, fidx;
      bit fset, ex;
      logic [31:0] fpc, fval;
      trace_entry_t c;
      for (int i = 0; i < DEPTH; i++)
        load(i, mk($urandom, 1'($urandom), 5'($urandom_range(0, 3)), $urandom_range(0, 3)));
      cnt = $urandom_range(0, DEPTH);
      k = $urandom_range(0, cnt + 2);
      ex = 1'($urandom) && (k > 0);
      m = 0; fset = 0; fidx = 0; fpc = 0; fval = 0;
      start(cnt);
      for (int i = 0; i < k; i++) begin
        if (i < cnt && $urandom_range(0, 3) != 0) begin
          c = mdl[i];
          case ($urandom_range(0, 5))
            0: c.rd_idx = 0;
            1: c.rd_val ^= 32'h1;
            2: c.rd_we = ~c.rd_we;
            3: c.pc += 4;
            default: ;
          endcase
        end else c = mk($urandom, 1'($urandom), 5'($urandom_range(0, 3)), $urandom);
        if (i >= cnt || !model_match(mdl[i], c)) begin
          m++;
          if (!fset) begin fset = 1; fidx = (i < cnt) ? i : cnt; fpc = c.pc; fval = c.rd_val; end
        end
        commit(c, ex && (i == k - 1));
        if (!(ex && i == k - 1))
          chk($sformatf("rnd%0d_c%0d", r, i), {o_checked_count, o_mismatch_count}, {4'(i + 1), 16'(m)});
      end
      if (!ex) do_exit();
      if (((k < cnt) ? k : cnt) != cnt) begin
        m++;
        if (!fset) begin fset = 1; fidx = cnt; fpc = 0; fval = 0; end
      end
      chk($sformatf("rnd%0d_end", r), {o_done, o_pass, o_fail, o_checked_count, o_mismatch_count},
          {1'b1, m == 0, m != 0, 4'(k), 16'(m)});
`ifdef LETC_TRACE_CHECKER_FIRST_FAIL_CAPTURE_EN
      chk($sformatf("rnd%0d_cap", r), {o_fail_idx, o_fail_pc, o_fail_val}, {4'(fidx), fpc, fval});
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
